// File: rtl/can_tx_queue.sv
// can_tx_queue
// Transmit message queue sitting directly upstream of the CAN transmit
// container. The host writes up to DEPTH frames, each an 11-bit ID plus a
// 64-bit payload. Once the bus is idle, the head frame is presented on
// address/data and send_data requests transmission. The frame is then
// tracked on rx until end-of-frame, and only then is the entry released.
//
// Optional feature macro: CAN_TXQ_TIMEOUT_EN
//   When defined, a per-frame bit-sample counter aborts a frame after
//   TIMEOUT_BITS samples, pulsing timeout and dropping the head entry.
//   When undefined, the frame wait is unbounded and timeout stays 0.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   baud_clk   in   bit-rate clock; its rising edge marks a sample point
//   rx         in   CAN receive line (1 = recessive)
//   wr_en      in   enqueue strobe
//   wr_id      in   [10:0] frame ID to enqueue
//   wr_data    in   [63:0] payload to enqueue
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  [PTR_W:0] occupancy
//   address    out  [10:0] ID of the frame in flight
//   data       out  [63:0] payload of the frame in flight
//   send_data  out  transmit request
//   busy       out  high outside IDLE
//   done       out  one-cycle pulse on frame completion
//   timeout    out  one-cycle pulse on frame abort
module can_tx_queue #(
  parameter int DEPTH        = 4,
  parameter int PTR_W        = 2,
  parameter int IDLE_BITS    = 11,
  parameter int TIMEOUT_BITS = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_clk,
  input  logic             rx,
  input  logic             wr_en,
  input  logic [10:0]      wr_id,
  input  logic [63:0]      wr_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic [10:0]      address,
  output logic [63:0]      data,
  output logic             send_data,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam int IC_W = $clog2(IDLE_BITS + 1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_EOF
  } state_t;

  state_t r_state, w_state_nxt;

  // Bit sampling
  logic r_baud_q;
  logic w_bsamp, w_rec, w_dom;

  assign w_bsamp = baud_clk & ~r_baud_q;
  assign w_rec   = w_bsamp & rx;
  assign w_dom   = w_bsamp & ~rx;

  always_ff @(posedge clk) begin
    if (rst) r_baud_q <= 1'b0;
    else     r_baud_q <= baud_clk;
  end

  // Bus-idle counter
  logic [IC_W-1:0] r_idle_cnt;
  logic            w_bus_idle;

  assign w_bus_idle = (r_idle_cnt == IC_W'(IDLE_BITS));

  always_ff @(posedge clk) begin
    if (rst)                            r_idle_cnt <= '0;
    else if (w_dom)                     r_idle_cnt <= '0;
    else if (w_rec && !w_bus_idle)      r_idle_cnt <= r_idle_cnt + 1'b1;
  end

  // Queue storage
  logic [10:0]      r_id_mem   [DEPTH];
  logic [63:0]      r_data_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_wr_acc, w_pop;

  assign full     = (r_count == FULL_CNT);
  assign empty    = (r_count == '0);
  assign count    = r_count;
  // Fullness is judged before any same-cycle pop, so a write into a full
  // queue is lost even when the head is released on that edge.
  assign w_wr_acc = wr_en & ~full;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_id_mem[r_wptr]   <= wr_id;
      r_data_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
      case ({w_wr_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame abort counter
  logic w_frm_last;
  logic w_load;

`ifdef CAN_TXQ_TIMEOUT_EN
  localparam int FC_W = $clog2(TIMEOUT_BITS + 1);
  logic [FC_W-1:0] r_frm_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_load || (r_state == S_SEND && w_dom))
      r_frm_cnt <= '0;
    else if ((r_state == S_SEND || r_state == S_WAIT_EOF) && w_bsamp)
      r_frm_cnt <= r_frm_cnt + 1'b1;
  end

  assign w_frm_last = (r_frm_cnt == FC_W'(TIMEOUT_BITS - 1));
`else
  assign w_frm_last = 1'b0;
`endif

  // FSM
  logic w_done_nxt, w_tout_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_tout_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!empty && w_bus_idle) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_dom) begin
          w_state_nxt = S_WAIT_EOF;
        end else if (w_bsamp && w_frm_last) begin
          w_tout_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_EOF: begin
        // The SOF sample cleared idle_cnt, so in this state it equals the
        // run of consecutive recessive samples since SOF.
        if (w_rec && r_idle_cnt == IC_W'(IDLE_BITS - 1)) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_bsamp && w_frm_last) begin
          w_tout_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_pop     = w_done_nxt | w_tout_nxt;
  assign send_data = (r_state == S_SEND);
  assign busy      = (r_state != S_IDLE);

  // Registered outputs
  logic [10:0] r_addr;
  logic [63:0] r_data;
  logic        r_done, r_tout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_data <= '0;
      r_done <= 1'b0;
      r_tout <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      r_tout <= w_tout_nxt;
      if (w_load) begin
        r_addr <= r_id_mem[r_rptr];
        r_data <= r_data_mem[r_rptr];
      end
    end
  end

  assign address = r_addr;
  assign data    = r_data;
  assign done    = r_done;
  assign timeout = r_tout;

endmodule

// File: tb/tb_can_tx_queue.sv
module tb_can_tx_queue;
  localparam int DEPTH        = 4;
  localparam int PTR_W        = 2;
  localparam int IDLE_BITS    = 11;
  localparam int TIMEOUT_BITS = 200;

  logic           clk = 1'b0;
  logic           rst, baud_clk, rx, wr_en;
  logic [10:0]    wr_id;
  logic [63:0]    wr_data;
  logic           full, empty, send_data, busy, done, timeout;
  logic [PTR_W:0] count;
  logic [10:0]    address;
  logic [63:0]    data;

  can_tx_queue #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .IDLE_BITS(IDLE_BITS), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk(clk), .rst(rst), .baud_clk(baud_clk), .rx(rx), .wr_en(wr_en),
    .wr_id(wr_id), .wr_data(wr_data), .full(full), .empty(empty), .count(count),
    .address(address), .data(data), .send_data(send_data), .busy(busy),
    .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] id;
    logic [63:0] pl;
  } ent_t;

  // Reference model: the queue as the host sees it (head = frame on the bus).
  ent_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.id = 11'($urandom);
    e.pl = {$urandom, $urandom};
    return e;
  endfunction

  // One bit sample: baud_clk low for a cycle, then a rising edge with rx = b.
  // Returns just after the clk edge that processed the sample. An optional
  // write is presented on that same edge.
  task automatic sample(input logic b, input logic do_wr, input ent_t e);
    baud_clk = 1'b0;
    @(negedge clk);
    rx       = b;
    baud_clk = 1'b1;
    if (do_wr) begin
      wr_en   = 1'b1;
      wr_id   = e.id;
      wr_data = e.pl;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Present a write on the next edge; wr_en is left high for back-to-back use.
  task automatic push(input ent_t e);
    wr_en   = 1'b1;
    wr_id   = e.id;
    wr_data = e.pl;
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    @(negedge clk);
    chk("push_count", 64'(count), 64'(exp_q.size()));
    chk("push_full",  64'(full),  64'(exp_q.size() == DEPTH));
    chk("push_empty", 64'(empty), 64'(exp_q.size() == 0));
  endtask

  task automatic wait_send(input int budget);
    int k = 0;
    while (!send_data && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_send", 64'(send_data), 64'd1);
  endtask

  // Random body with a dominant bit forced after five recessive bits and at
  // the end, so only the trailing recessive run can close the frame.
  task automatic body_bits(input int n, input logic chk_done);
    int   ones = 0;
    logic b;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1 || ones == 5) b = 1'b0;
      else                         b = 1'($urandom_range(0, 1));
      ones = b ? ones + 1 : 0;
      sample(b, 1'b0, '0);
      if (chk_done) chk("body_done_lo", 64'(done), 64'd0);
    end
  endtask

  task automatic send_frame(input int nbody, input logic do_wr, input ent_t we);
    ent_t h;
    logic acc;
    h = exp_q[0];
    chk("send_hi", 64'(send_data), 64'd1);
    chk("addr",    64'(address),   64'(h.id));
    chk("data",    data,           h.pl);
    sample(1'b0, 1'b0, '0);
    chk("sof_send_lo", 64'(send_data), 64'd0);
    chk("sof_busy",    64'(busy),      64'd1);
    body_bits(nbody, 1'b1);
    for (int i = 1; i <= IDLE_BITS; i++) begin
      if (i == IDLE_BITS) begin
        sample(1'b1, do_wr, we);
        acc = do_wr && (exp_q.size() < DEPTH);
        void'(exp_q.pop_front());
        if (acc) exp_q.push_back(we);
        chk("done_hi",     64'(done),    64'd1);
        chk("tout_lo",     64'(timeout), 64'd0);
        chk("done_count",  64'(count),   64'(exp_q.size()));
        chk("done_send",   64'(send_data), 64'd0);
      end else begin
        sample(1'b1, 1'b0, '0);
        chk("eof_done_lo", 64'(done), 64'd0);
      end
    end
    @(negedge clk);
    chk("done_pulse", 64'(done),    64'd0);
    chk("addr_hold",  64'(address), 64'(h.id));
    chk("data_hold",  data,         h.pl);
    @(negedge clk);
    chk("next_send", 64'(send_data), 64'(exp_q.size() != 0));
    chk("next_busy", 64'(busy),      64'(exp_q.size() != 0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of stimulus, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ent_t e, c;
    rst = 1'b1; baud_clk = 1'b0; rx = 1'b1; wr_en = 1'b0; wr_id = '0; wr_data = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_send",  64'(send_data), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_tout",  64'(timeout),   64'd0);
    chk("rst_full",  64'(full),      64'd0);
    chk("rst_empty", 64'(empty),     64'd1);
    chk("rst_count", 64'(count),     64'd0);
    chk("rst_addr",  64'(address),   64'd0);
    chk("rst_data",  data,           64'd0);
    rst = 1'b0;

    // Bus integration: 11 recessive samples before the first request
    e.id = 11'h123; e.pl = 64'hDEADBEEF_CAFEF00D;
    push(e);
    wr_en = 1'b0;
    for (int i = 1; i < IDLE_BITS; i++) begin
      sample(1'b1, 1'b0, '0);
      chk("integ_send_lo", 64'(send_data), 64'd0);
      chk("integ_busy_lo", 64'(busy),      64'd0);
    end
    sample(1'b1, 1'b0, '0);
    chk("integ_edge_send", 64'(send_data), 64'd0);
    @(negedge clk);
    chk("load_send_lo", 64'(send_data), 64'd0);
    chk("load_busy",    64'(busy),      64'd1);
    @(negedge clk);
    chk("send_rise", 64'(send_data), 64'd1);

    // Frame completion, count 1 -> 0
    send_frame(40, 1'b0, '0);

    // Full / overflow: five back-to-back writes into DEPTH=4
    for (int i = 0; i < 5; i++) push(rand_ent());
    wr_en = 1'b0;
    chk("ovf_full",  64'(full),  64'd1);
    chk("ovf_count", 64'(count), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      wait_send(20);
      send_frame(int'($urandom_range(8, 40)), 1'b0, '0);
    end
    chk("ovf_empty", 64'(empty), 64'd1);

    // Simultaneous write and pop at count == 2
    push(rand_ent());
    push(rand_ent());
    wr_en = 1'b0;
    wait_send(20);
    c = rand_ent();
    send_frame(int'($urandom_range(8, 40)), 1'b1, c);
    chk("simul_count", 64'(count), 64'd2);
    send_frame(int'($urandom_range(8, 40)), 1'b0, '0);
    chk("last_is_new", 64'(exp_q[0].id), 64'(c.id));
    send_frame(int'($urandom_range(8, 40)), 1'b0, '0);

    // Bus stuck dominant after SOF
    push(rand_ent());
    wr_en = 1'b0;
    wait_send(20);
    sample(1'b0, 1'b0, '0);
    chk("stuck_sof", 64'(send_data), 64'd0);
`ifdef CAN_TXQ_TIMEOUT_EN
    for (int i = 1; i < TIMEOUT_BITS; i++) begin
      sample(1'b0, 1'b0, '0);
      chk("tout_early", 64'(timeout), 64'd0);
    end
    sample(1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    chk("tout_hi",    64'(timeout),   64'd1);
    chk("tout_count", 64'(count),     64'(exp_q.size()));
    chk("tout_busy",  64'(busy),      64'd0);
    chk("tout_done",  64'(done),      64'd0);
    @(negedge clk);
    chk("tout_pulse", 64'(timeout), 64'd0);
`else
    for (int i = 0; i < TIMEOUT_BITS + 10; i++) sample(1'b0, 1'b0, '0);
    chk("stuck_busy",  64'(busy),    64'd1);
    chk("stuck_tout",  64'(timeout), 64'd0);
    chk("stuck_done",  64'(done),    64'd0);
    chk("stuck_count", 64'(count),   64'd1);
`endif

    // Reset mid-frame in WAIT_EOF with count == 3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("rst2_count", 64'(count), 64'd0);
    for (int i = 0; i < 3; i++) push(rand_ent());
    wr_en = 1'b0;
    for (int i = 0; i < IDLE_BITS; i++) sample(1'b1, 1'b0, '0);
    wait_send(20);
    sample(1'b0, 1'b0, '0);
    body_bits(10, 1'b0);
    chk("mid_count", 64'(count), 64'd3);
    chk("mid_busy",  64'(busy),  64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("mrst_count", 64'(count),     64'd0);
    chk("mrst_send",  64'(send_data), 64'd0);
    chk("mrst_busy",  64'(busy),      64'd0);
    chk("mrst_done",  64'(done),      64'd0);
    chk("mrst_empty", 64'(empty),     64'd1);
    chk("mrst_addr",  64'(address),   64'd0);
    for (int i = 0; i < IDLE_BITS + 1; i++) begin
      sample(1'b1, 1'b0, '0);
      chk("post_rst_done", 64'(done), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
